keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
Scans a 4x4 matrix keypad through time-multiplexed, active-low column strobes and reads the row lines back. This is the input counterpart of the multiplexed seven-segment display driver. It debounces whole-keypad scan frames and reports one key as a 4-bit code with a single-cycle valid strobe and a held level. It sits between the board keypad pins and the digital-clock set/control logic.

Parameters:
SCAN_DIV_BITS, 13, width of the prescaler; one scan tick every 2^SCAN_DIV_BITS clk cycles.
DEBOUNCE_FRAMES, 3, number of consecutive identical frame results needed to accept a press or release (range 1..15).

Ports:
clk  input  1  system clock.
rst  input  1  asynchronous, active-high reset.
row  input  4  keypad row lines, active-low, pulled up externally, asynchronous to clk.
col  output  4  column strobes, active-low, exactly one low at a time.
key_code  output  4  debounced key code, equal to 4*row_index + col_index.
key_valid  output  1  one-cycle pulse when a new key is accepted.
key_down  output  1  high while the accepted key remains pressed.

Behaviour:
- Reset (async, rst=1): prescaler=0, column index=0, col=4'b1110, synchroniser=4'b1111, frame accumulator cleared, stable count=0, last frame result = "none pressed". Outputs: key_code=0, key_valid=0, key_down=0.
- Synchroniser: row passes through 2 flip-flops (rs) before any use.
- Prescaler: free-running SCAN_DIV_BITS-bit counter. A tick is asserted for one clk cycle when the counter is all-ones.
- Each tick:
  - Sample rs for the current column.
  - Record the column's result if the frame has no hit yet and rs != 4'b1111. The hit row is the lowest index i with rs[i]=0.
  - Advance the column index 0->1->2->3->0.
  - col pattern by index: 1110, 1101, 1011, 0111.
- Priority: the first hit in scan order wins (lowest column, then lowest row). Additional keys pressed in the same frame are ignored.
- Frame end: the tick that samples column 3. The frame result is {pressed, code}. The accumulator clears for the next frame in the same cycle.
- Debounce at each frame end:
  - If the result equals the last frame result, stable count increments, saturating at DEBOUNCE_FRAMES.
  - Otherwise stable count=1 and the last result is updated.
- Acceptance, on the frame end where stable count reaches DEBOUNCE_FRAMES:
  - Pressed result whose code differs from the current key_code, or key_down=0: key_code<=code, key_down<=1, key_valid=1 for exactly that one cycle.
  - Released result: key_down<=0, key_code holds its value, no pulse.
- Held key: no repeat pulses. Key_valid pulses exactly once per accepted press.
- Direct change A->B with no release frame between: once B is stable, key_code=B and a new key_valid pulse fires. key_down stays 1 throughout.
- Latency: a clean press present before frame k starts produces key_valid at the end of frame k+DEBOUNCE_FRAMES-1. One frame = 4*2^SCAN_DIV_BITS cycles.
- Reset mid-operation: all state returns to reset values immediately. A key still held is re-accepted after DEBOUNCE_FRAMES full frames with a fresh key_valid pulse.

Test Plan:
1. Reset: assert rst, check col=1110, key_code=0, key_valid=0, key_down=0. Release rst, check col steps 1110->1101->1011->0111->1110 every 16 clks (SCAN_DIV_BITS=4).
2. Single press: bench model pulls row2 low whenever col1 is low (SCAN_DIV_BITS=4, DEBOUNCE_FRAMES=3). Expect one key_valid pulse, key_code=9, key_down=1 at the end of the 3rd full frame. No further pulses over 10 more frames.
3. Bounce: toggle the key every frame for 4 frames, then hold. Expect no pulse during bouncing, and exactly one pulse 3 frames after the hold begins.
4. Release: after case 2, release the key. Expect key_down=0 at the 3rd released frame end, key_code stays 9, no pulse.
5. Two keys: hold row0/col3 (code 3) and row1/col0 (code 4) together. Expect key_code=4. Then release code 4 only: expect a new pulse with key_code=3 and key_down held 1.
6. Reset while holding code 9: key_down drops to 0 asynchronously. After release of rst, key_valid re-pulses with code 9 after 3 frames.

Source files
------------

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad one column per prescaler tick.
// Whole-keypad frames are debounced. Accepted keys give a one-cycle key_valid pulse and a held key_down level.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV_BITS   = 13,
  parameter int unsigned DEBOUNCE_FRAMES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned RES_W = 5;
  localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEBOUNCE_FRAMES);

  logic [SCAN_DIV_BITS-1:0] presc;
  logic [1:0]               col_idx;
  logic [3:0]               rs_meta;
  logic [3:0]               rs;
  logic                     acc_hit;
  logic [3:0]               acc_code;
  logic [CNT_W-1:0]         stable_cnt;
  logic [RES_W-1:0]         last_res;

  logic                     tick_c;
  logic                     row_hit_c;
  logic                     frame_end_c;
  logic [1:0]               hit_row_c;
  logic [3:0]               samp_code_c;
  logic [RES_W-1:0]         frame_res_c;
  logic                     same_c;
  logic [CNT_W-1:0]         cnt_next_c;
  logic                     accept_c;

  // Frame result and debounce decision for the current tick.
  always_comb begin
    tick_c      = &presc;
    row_hit_c   = (rs != 4'b1111);
    hit_row_c   = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rs[i]) hit_row_c = 2'(i);
    end
    samp_code_c = {hit_row_c, col_idx};
    frame_end_c = tick_c && (col_idx == 2'd3);

    if (acc_hit)        frame_res_c = {1'b1, acc_code};
    else if (row_hit_c) frame_res_c = {1'b1, samp_code_c};
    else                frame_res_c = RES_W'(0);

    same_c = (frame_res_c == last_res);
    if (!same_c)                  cnt_next_c = CNT_W'(1);
    else if (stable_cnt >= DEB_MAX) cnt_next_c = DEB_MAX;
    else                          cnt_next_c = stable_cnt + CNT_W'(1);

    // Accept only on the frame that first reaches the threshold, not while saturated.
    accept_c = (cnt_next_c == DEB_MAX) && !(same_c && (stable_cnt == DEB_MAX));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc      <= '0;
      col_idx    <= 2'd0;
      col        <= 4'b1110;
      rs_meta    <= 4'b1111;
      rs         <= 4'b1111;
      acc_hit    <= 1'b0;
      acc_code   <= 4'd0;
      stable_cnt <= '0;
      last_res   <= '0;
      key_code   <= 4'd0;
      key_valid  <= 1'b0;
      key_down   <= 1'b0;
    end else begin
      rs_meta   <= row;
      rs        <= rs_meta;
      presc     <= presc + SCAN_DIV_BITS'(1);
      key_valid <= 1'b0;
      if (tick_c) begin
        col_idx <= col_idx + 2'd1;
        col     <= {col[2:0], col[3]};
        if (frame_end_c) begin
          acc_hit    <= 1'b0;
          acc_code   <= 4'd0;
          stable_cnt <= cnt_next_c;
          if (!same_c) last_res <= frame_res_c;
          if (accept_c) begin
            if (frame_res_c[4]) begin
              // A still-held key that briefly glitched is not re-announced.
              if ((frame_res_c[3:0] != key_code) || !key_down) begin
                key_code  <= frame_res_c[3:0];
                key_down  <= 1'b1;
                key_valid <= 1'b1;
              end
            end else begin
              key_down <= 1'b0;
            end
          end
        end else if (!acc_hit && row_hit_c) begin
          acc_hit  <= 1'b1;
          acc_code <= samp_code_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: drives an ideal 4x4 keypad matrix frame by frame and checks the scanner
// against a frame-history reference model.
module tb_keypad_scanner;

  localparam int unsigned SDB   = 4;
  localparam int unsigned DEB   = 3;
  localparam int          TICK  = 1 << SDB;
  localparam int          FRAME = 4 * TICK;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_down;
  logic [15:0] keys;

  int vectors;
  int miscompares;

  int         hist[$];
  bit         m_pulse;
  bit         m_down;
  logic [3:0] m_code;

  bit o_pulse_end;
  int o_pulse_other;
  int o_col_bad;

  keypad_scanner #(.SCAN_DIV_BITS(SDB), .DEBOUNCE_FRAMES(DEB)) dut (
    .clk(clk), .rst(rst), .row(row), .col(col),
    .key_code(key_code), .key_valid(key_valid), .key_down(key_down)
  );

  always #5 clk = ~clk;

  // Ideal switch matrix: a pressed key shorts its row to its column when that column is driven low.
  always_comb begin
    row = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[4*r+c] && !col[c]) row[r] = 1'b0;
  end

  function automatic int frame_result(input logic [15:0] k);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (k[4*r+c]) return 4*r + c;
    return -1;
  endfunction

  task automatic model_reset();
    hist.delete();
    m_pulse = 1'b0;
    m_down  = 1'b0;
    m_code  = 4'd0;
  endtask

  // A result is accepted on the frame that completes a run of exactly DEB identical results.
  task automatic model_frame(input logic [15:0] k);
    int res;
    int run;
    res = frame_result(k);
    hist.push_back(res);
    run = 0;
    for (int i = hist.size() - 1; i >= 0 && hist[i] == res; i--) run++;
    m_pulse = 1'b0;
    if (run == int'(DEB)) begin
      if (res < 0) m_down = 1'b0;
      else if (!m_down || m_code != 4'(res)) begin
        m_pulse = 1'b1;
        m_down  = 1'b1;
        m_code  = 4'(res);
      end
    end
    if (hist.size() > 32) void'(hist.pop_front());
  endtask

  // Holds key set k for one full frame, recording strobe timing and column-pattern errors.
  task automatic run_frame(input logic [15:0] k);
    logic [3:0] exp_col;
    keys          = k;
    o_pulse_end   = 1'b0;
    o_pulse_other = 0;
    o_col_bad     = 0;
    for (int j = 1; j <= FRAME; j++) begin
      @(posedge clk);
      #1;
      exp_col = ~(4'b0001 << ((j / TICK) % 4));
      if (col !== exp_col) o_col_bad++;
      if (key_valid === 1'b1) begin
        if (j == FRAME) o_pulse_end = 1'b1;
        else o_pulse_other++;
      end
    end
    model_frame(k);
  endtask

  task automatic test_reset();
    keys = 16'h0000;
    rst  = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (col !== 4'b1110 || key_code !== 4'd0 || key_valid !== 1'b0 || key_down !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: col=%b code=%0d valid=%b down=%b, want col=1110 code=0 valid=0 down=0",
               col, key_code, key_valid, key_down);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int f = 1; f <= 2; f++) begin
      run_frame(16'h0000);
      vectors++;
      if (o_col_bad != 0) begin
        miscompares++;
        $display("FAIL reset_col_steps f%0d: %0d bad col samples, want 0", f, o_col_bad);
      end
      vectors++;
      if (o_pulse_end || o_pulse_other != 0 || key_down !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_idle f%0d: pulse=%b other=%0d down=%b, want none", f, o_pulse_end, o_pulse_other, key_down);
      end
    end
  endtask

  task automatic test_single_press();
    int pulse_frame = 0;
    for (int f = 1; f <= int'(DEB) + 10; f++) begin
      run_frame(16'h0200);
      vectors++;
      if (o_pulse_end !== m_pulse || o_pulse_other != 0) begin
        miscompares++;
        $display("FAIL single_press_pulse f%0d: end=%b other=%0d, want end=%b other=0", f, o_pulse_end, o_pulse_other, m_pulse);
      end
      vectors++;
      if (key_down !== m_down || key_code !== m_code) begin
        miscompares++;
        $display("FAIL single_press_state f%0d: down=%b code=%0d, want down=%b code=%0d", f, key_down, key_code, m_down, m_code);
      end
      if (o_pulse_end) pulse_frame = (pulse_frame == 0) ? f : -1;
    end
    vectors++;
    if (pulse_frame != int'(DEB) || key_code !== 4'd9 || key_down !== 1'b1) begin
      miscompares++;
      $display("FAIL single_press_latency: pulse frame=%0d code=%0d down=%b, want frame=%0d code=9 down=1",
               pulse_frame, key_code, key_down, DEB);
    end
  endtask

  task automatic test_release();
    for (int f = 1; f <= int'(DEB); f++) begin
      run_frame(16'h0000);
      vectors++;
      if (o_pulse_end || o_pulse_other != 0 || key_code !== 4'd9 || key_down !== (f < int'(DEB))) begin
        miscompares++;
        $display("FAIL release f%0d: pulse=%b other=%0d code=%0d down=%b, want no pulse code=9 down=%0d",
                 f, o_pulse_end, o_pulse_other, key_code, key_down, (f < int'(DEB)));
      end
    end
  endtask

  task automatic test_bounce();
    int pulses = 0;
    for (int f = 0; f < 4; f++) begin
      run_frame((f % 2 == 0) ? 16'h0040 : 16'h0000);
      pulses += int'(o_pulse_end) + o_pulse_other;
    end
    vectors++;
    if (pulses != 0 || key_down !== 1'b0) begin
      miscompares++;
      $display("FAIL bounce_quiet: pulses=%0d down=%b, want 0 pulses down=0", pulses, key_down);
    end
    for (int f = 1; f <= int'(DEB); f++) begin
      run_frame(16'h0040);
      vectors++;
      if (o_pulse_end !== m_pulse || o_pulse_other != 0 || o_pulse_end !== (f == int'(DEB))) begin
        miscompares++;
        $display("FAIL bounce_hold f%0d: end=%b other=%0d, want end=%b", f, o_pulse_end, o_pulse_other, (f == int'(DEB)));
      end
    end
    vectors++;
    if (key_code !== 4'd6 || key_down !== 1'b1) begin
      miscompares++;
      $display("FAIL bounce_accept: code=%0d down=%b, want code=6 down=1", key_code, key_down);
    end
  endtask

  task automatic test_two_keys();
    for (int f = 1; f <= int'(DEB); f++) run_frame(16'h0018);
    vectors++;
    if (key_code !== 4'd4 || key_down !== 1'b1 || o_pulse_end !== 1'b1) begin
      miscompares++;
      $display("FAIL two_keys_priority: code=%0d down=%b pulse=%b, want code=4 down=1 pulse=1", key_code, key_down, o_pulse_end);
    end
    for (int f = 1; f <= int'(DEB); f++) begin
      run_frame(16'h0008);
      vectors++;
      if (key_down !== 1'b1 || o_pulse_end !== (f == int'(DEB)) || o_pulse_other != 0 || o_pulse_end !== m_pulse) begin
        miscompares++;
        $display("FAIL two_keys_change f%0d: down=%b end=%b other=%0d, want down=1 end=%b", f, key_down, o_pulse_end, o_pulse_other, (f == int'(DEB)));
      end
    end
    vectors++;
    if (key_code !== 4'd3) begin
      miscompares++;
      $display("FAIL two_keys_code: code=%0d, want 3", key_code);
    end
  endtask

  task automatic test_reset_hold();
    for (int f = 1; f <= int'(DEB); f++) run_frame(16'h0200);
    vectors++;
    if (key_code !== 4'd9 || key_down !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_hold_pre: code=%0d down=%b, want code=9 down=1", key_code, key_down);
    end
    repeat (20) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    vectors++;
    if (key_down !== 1'b0 || key_code !== 4'd0 || col !== 4'b1110) begin
      miscompares++;
      $display("FAIL reset_hold_async: down=%b code=%0d col=%b, want down=0 code=0 col=1110", key_down, key_code, col);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int f = 1; f <= int'(DEB); f++) begin
      run_frame(16'h0200);
      vectors++;
      if (o_pulse_end !== (f == int'(DEB)) || o_pulse_other != 0 || o_pulse_end !== m_pulse) begin
        miscompares++;
        $display("FAIL reset_hold_repulse f%0d: end=%b other=%0d, want end=%b", f, o_pulse_end, o_pulse_other, (f == int'(DEB)));
      end
    end
    vectors++;
    if (key_code !== 4'd9 || key_down !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_hold_code: code=%0d down=%b, want code=9 down=1", key_code, key_down);
    end
  endtask

  task automatic test_random();
    logic [15:0] k;
    int n;
    int hold;
    for (int s = 0; s < 40; s++) begin
      k = 16'h0000;
      n = $urandom_range(0, 2);
      for (int i = 0; i < n; i++) k[$urandom_range(0, 15)] = 1'b1;
      hold = $urandom_range(1, 4);
      for (int f = 0; f < hold; f++) begin
        run_frame(k);
        vectors++;
        if (o_pulse_end !== m_pulse || o_pulse_other != 0 || o_col_bad != 0) begin
          miscompares++;
          $display("FAIL random_pulse s%0d f%0d keys=%h: end=%b other=%0d colbad=%0d, want end=%b",
                   s, f, k, o_pulse_end, o_pulse_other, o_col_bad, m_pulse);
        end
        vectors++;
        if (key_down !== m_down || key_code !== m_code) begin
          miscompares++;
          $display("FAIL random_state s%0d f%0d keys=%h: down=%b code=%0d, want down=%b code=%0d",
                   s, f, k, key_down, key_code, m_down, m_code);
        end
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_single_press();
    test_release();
    test_bounce();
    test_two_keys();
    test_reset_hold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
